// File: rtl/instr_pkg.sv
// Shared opcode constants, execute-branch identifiers and the decoded instruction record
// used by the issue stage and its field decoder.
package instr_pkg;

    localparam logic [4:0] OP_NOP         = 5'd0;
    localparam logic [4:0] OP_MADD        = 5'd1;
    localparam logic [4:0] OP_ADD         = 5'd2;
    localparam logic [4:0] OP_SUB         = 5'd3;
    localparam logic [4:0] OP_MOV         = 5'd4;
    localparam logic [4:0] OP_ABS         = 5'd5;
    localparam logic [4:0] OP_MACZ        = 5'd6;
    localparam logic [4:0] OP_MAC         = 5'd7;
    localparam logic [4:0] OP_MOV_ACC     = 5'd8;
    localparam logic [4:0] OP_DELAY_WRITE = 5'd9;
    localparam logic [4:0] OP_DELAY_READ  = 5'd10;
    localparam logic [4:0] OP_LUT         = 5'd11;
    localparam logic [4:0] OP_MEM_WRITE   = 5'd12;
    localparam logic [4:0] OP_MEM_READ    = 5'd13;

    localparam logic [4:0]  MISC_OPCODE_MIN = OP_ADD;
    localparam int unsigned N_MISC_OPS      = 4;
    localparam int unsigned MISC_OP_W       = $clog2(N_MISC_OPS);

    typedef enum logic [2:0] {
        INSTR_BRANCH_MADD  = 3'd0,
        INSTR_BRANCH_MISC  = 3'd1,
        INSTR_BRANCH_MAC   = 3'd2,
        INSTR_BRANCH_DELAY = 3'd3,
        INSTR_BRANCH_LUT   = 3'd4,
        INSTR_BRANCH_MEM   = 3'd5
    } instr_branch_t;

    localparam int unsigned N_INSTR_BRANCHES = 6;

    typedef struct packed {
        logic       is_reg;
        logic [3:0] idx;
    } operand_t;

    typedef struct packed {
        logic [4:0]           op;
        logic                 fmt;
        operand_t             a;
        operand_t             b;
        operand_t             c;
        logic [3:0]           dest;
        logic [4:0]           shift;
        logic                 sat_dis;
        logic                 shift_disable;
        logic [11:0]          res_addr;
        logic                 a_needed;
        logic                 b_needed;
        logic                 c_needed;
        logic                 accumulator_needed;
        logic                 writes_channel;
        logic                 writes_acc;
        logic                 writes_external;
        instr_branch_t        branch;
        logic [MISC_OP_W-1:0] misc_op;
    } decoded_instr_t;

endpackage

// File: rtl/instr_field_decode.sv
// Purely combinational split of a 32-bit block instruction into the decoded record.
module instr_field_decode
    import instr_pkg::*;
(
    input  logic [31:0]    instr,
    output decoded_instr_t rec
);

    always_comb begin
        rec               = '0;
        rec.op            = instr[4:0];
        rec.fmt           = instr[5];
        rec.a             = instr[10:6];
        rec.b             = instr[15:11];
        rec.shift_disable = instr[31];
        if (!instr[5]) begin
            rec.c       = instr[20:16];
            rec.dest    = instr[24:21];
            rec.shift   = instr[29:25];
            rec.sat_dis = instr[30];
        end else begin
            rec.dest     = instr[19:16];
            rec.res_addr = instr[31:20];
        end
        rec.misc_op = MISC_OP_W'(instr[4:0] - MISC_OPCODE_MIN);
        rec.branch  = INSTR_BRANCH_MISC;

        // Unlisted opcodes decode as a NOP: no operands, no writes.
        case (instr[4:0])
            OP_MADD: begin
                rec.a_needed = 1'b1; rec.b_needed = 1'b1; rec.c_needed = 1'b1;
                rec.writes_channel = 1'b1;
                rec.branch = INSTR_BRANCH_MADD;
            end
            OP_ADD, OP_SUB: begin
                rec.a_needed = 1'b1; rec.b_needed = 1'b1;
                rec.writes_channel = 1'b1;
            end
            OP_MOV, OP_ABS: begin
                rec.a_needed = 1'b1;
                rec.writes_channel = 1'b1;
            end
            OP_MACZ, OP_MAC: begin
                rec.a_needed = 1'b1; rec.b_needed = 1'b1;
                rec.writes_acc = 1'b1;
                rec.branch = INSTR_BRANCH_MAC;
            end
            OP_MOV_ACC: begin
                rec.accumulator_needed = 1'b1;
                rec.writes_channel = 1'b1;
                rec.branch = INSTR_BRANCH_MAC;
            end
            OP_DELAY_WRITE: begin
                rec.a_needed = 1'b1;
                rec.writes_external = 1'b1;
                rec.branch = INSTR_BRANCH_DELAY;
            end
            OP_DELAY_READ: begin
                rec.writes_channel = 1'b1;
                rec.branch = INSTR_BRANCH_DELAY;
            end
            OP_LUT: begin
                rec.a_needed = 1'b1;
                rec.writes_channel = 1'b1;
                rec.branch = INSTR_BRANCH_LUT;
            end
            OP_MEM_WRITE: begin
                rec.a_needed = 1'b1; rec.b_needed = 1'b1;
                rec.writes_external = 1'b1;
                rec.branch = INSTR_BRANCH_MEM;
            end
            OP_MEM_READ: begin
                rec.a_needed = 1'b1;
                rec.writes_channel = 1'b1;
                rec.branch = INSTR_BRANCH_MEM;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_issue_stage.sv
// Registered issue stage: one holding register, channel-register scoreboard and an
// in-flight accumulator-writer counter gating when a decoded record may leave.
module instr_issue_stage
    import instr_pkg::*;
#(
    parameter int unsigned  DATA_WIDTH   = 16,
    parameter int unsigned  N_REGS       = 16,
    parameter int unsigned  ACC_PEND_MAX = 7,
    parameter bit           SB_ENABLE    = 1'b1,
    localparam int unsigned REG_W        = $clog2(N_REGS),
    localparam int unsigned ACC_W        = $clog2(ACC_PEND_MAX + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output decoded_instr_t   out_rec,
    input  logic             wb_valid,
    input  logic [REG_W-1:0] wb_dest,
    input  logic             acc_done,
    output logic [15:0]      stall_cnt
);

    // The 32-bit encoding carries 4-bit register indices.
    if (N_REGS < 2 || N_REGS > 16 || DATA_WIDTH == 0) begin : g_bad_params
        $error("instr_issue_stage: unsupported N_REGS or DATA_WIDTH");
    end

    decoded_instr_t    dec_rec;
    decoded_instr_t    hold_rec;
    logic              hold_v, hold_v_d;
    logic [N_REGS-1:0] sb, sb_d;
    logic [ACC_W-1:0]  acc_pend, acc_d;
    logic              raw, waw, acc_hz, acc_ovf, hazard;
    logic              issue, accept, acc_inc, acc_dec;

    instr_field_decode u_decode (
        .instr (instr),
        .rec   (dec_rec)
    );

    assign raw = (hold_rec.a_needed & hold_rec.a.is_reg & sb[hold_rec.a.idx[REG_W-1:0]])
               | (hold_rec.b_needed & hold_rec.b.is_reg & sb[hold_rec.b.idx[REG_W-1:0]])
               | (hold_rec.c_needed & hold_rec.c.is_reg & sb[hold_rec.c.idx[REG_W-1:0]]);
    assign waw     = hold_rec.writes_channel & sb[hold_rec.dest[REG_W-1:0]];
    assign acc_hz  = hold_rec.accumulator_needed & (acc_pend != '0);
    assign acc_ovf = hold_rec.writes_acc & (acc_pend == ACC_W'(ACC_PEND_MAX));
    assign hazard  = SB_ENABLE && (raw || waw || acc_hz || acc_ovf);

    assign out_valid = hold_v & ~hazard;
    assign issue     = out_valid & out_ready;
    assign in_ready  = ~hold_v | issue;
    assign accept    = in_valid & in_ready & ~flush;
    assign out_rec   = hold_rec;

    assign acc_inc = issue & hold_rec.writes_acc;
    assign acc_dec = acc_done & (acc_pend != '0);

    always_comb begin
        hold_v_d = hold_v;
        sb_d     = sb;
        acc_d    = acc_pend;
        if (issue)  hold_v_d = 1'b0;
        if (accept) hold_v_d = 1'b1;
        // Retire clears first so a same-cycle issue to the same register wins.
        if (wb_valid) sb_d[wb_dest] = 1'b0;
        if (issue && hold_rec.writes_channel) sb_d[hold_rec.dest[REG_W-1:0]] = 1'b1;
        if (acc_inc && !acc_dec)      acc_d = acc_pend + 1'b1;
        else if (acc_dec && !acc_inc) acc_d = acc_pend - 1'b1;
        if (flush) begin
            hold_v_d = 1'b0;
            sb_d     = '0;
            acc_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_v    <= 1'b0;
            hold_rec  <= '0;
            sb        <= '0;
            acc_pend  <= '0;
            stall_cnt <= '0;
        end else begin
            hold_v   <= hold_v_d;
            sb       <= sb_d;
            acc_pend <= acc_d;
            if (accept) hold_rec <= dec_rec;
            if (hold_v && hazard && stall_cnt != '1) stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule
